// File: rtl/bridge_pkg.sv
// Shared constants and types for the data-bus bridge and its countdown timers.
// Address map, timer register offsets, CTRL layout, mode codes and FSM states.
package bridge_pkg;

    localparam logic [31:0] DM_TOP  = 32'h0000_2FFF;
    localparam logic [31:0] T0_BASE = 32'h0000_7F00;
    localparam logic [31:0] T1_BASE = 32'h0000_7F10;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_e;

    // Field order matches the CTRL bit positions above (im=3, mode=2:1, en=0).
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_unit.sv
// Memory-mapped countdown timer: CTRL/PRESET writable, COUNT read-only, sticky or pulsed irq.
// Stores commit at the clock edge of the store cycle; reads are combinational.
module timer_unit
    import bridge_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:2]  reg_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_e  state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;

    logic wr_ctrl, wr_preset;

    assign wr_ctrl   = sel & we & (reg_addr == OFF_CTRL[3:2]);
    assign wr_preset = sel & we & (reg_addr == OFF_PRESET[3:2]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    pend_d  = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    pend_d  = 1'b0;
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Register stores override FSM updates made in the same cycle.
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(wdata[3:0]);
            pend_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = wdata;
            pend_d   = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_addr)
            OFF_CTRL[3:2]:   rdata = {28'd0, ctrl_q};
            OFF_PRESET[3:2]: rdata = preset_q;
            OFF_COUNT[3:2]:  rdata = count_q;
            default:         rdata = '0;
        endcase
    end

    assign irq = ctrl_q.im & pend_q;

endmodule

// File: rtl/sys_bridge.sv
// Data-bus responder: decodes MEM accesses to DM or two timers, returns read data the same cycle.
// Single-cycle, no backpressure; erroneous stores are flagged and change no state.
module sys_bridge
    import bridge_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        ext_int,
    output logic [5:0]  hw_int,
    output logic        addr_err
);

    logic        sel_dm, sel_t0, sel_t1, unmapped;
    logic        tmr_we;
    logic [31:0] t0_rdata, t1_rdata;
    logic        t0_irq, t1_irq;

    assign sel_dm   = (addr <= DM_TOP);
    assign sel_t0   = (addr[31:4] == T0_BASE[31:4]) && (addr[3:2] != 2'b11);
    assign sel_t1   = (addr[31:4] == T1_BASE[31:4]) && (addr[3:2] != 2'b11);
    assign unmapped = ~(sel_dm | sel_t0 | sel_t1);

    // Only full-word stores reach the timers; partial ones are an error.
    assign tmr_we   = we & (be == 4'b1111);
    assign addr_err = unmapped | (we & (sel_t0 | sel_t1) & (be != 4'b1111));

    assign dm_we    = we & sel_dm;
    assign dm_be    = sel_dm ? be : 4'b0000;
    assign dm_addr  = addr;
    assign dm_wdata = wdata;

    timer_unit u_t0 (
        .Clk      (Clk),
        .Reset    (Reset),
        .sel      (sel_t0),
        .we       (tmr_we),
        .reg_addr (addr[3:2]),
        .wdata    (wdata),
        .rdata    (t0_rdata),
        .irq      (t0_irq)
    );

    timer_unit u_t1 (
        .Clk      (Clk),
        .Reset    (Reset),
        .sel      (sel_t1),
        .we       (tmr_we),
        .reg_addr (addr[3:2]),
        .wdata    (wdata),
        .rdata    (t1_rdata),
        .irq      (t1_irq)
    );

    always_comb begin
        rdata = '0;
        if (sel_dm)      rdata = dm_rdata;
        else if (sel_t0) rdata = t0_rdata;
        else if (sel_t1) rdata = t1_rdata;
    end

    assign hw_int = {3'b000, ext_int, t1_irq, t0_irq};

endmodule

// File: tb/tb_sys_bridge.sv
// Scoreboard bench for sys_bridge: directed scenarios plus random traffic against a reference model.
module tb_sys_bridge;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] addr, wdata, dm_rdata;
    logic [3:0]  be;
    logic        we, ext_int;
    logic [31:0] rdata, dm_addr, dm_wdata;
    logic        dm_we, addr_err;
    logic [3:0]  dm_be;
    logic [5:0]  hw_int;

    sys_bridge dut (
        .Clk(Clk), .Reset(Reset), .addr(addr), .wdata(wdata), .be(be), .we(we),
        .rdata(rdata), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .ext_int(ext_int),
        .hw_int(hw_int), .addr_err(addr_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic        err;
        logic [5:0]  hw;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 0;

    // Reference model: per-timer registers plus a phase
    // (0 stopped, 1 reload due, 2 counting down, 3 just expired).
    logic        m_en[2], m_im[2], m_pend[2];
    logic [1:0]  m_mode[2];
    logic [31:0] m_pre[2], m_cnt[2];
    int          m_ph[2];

    function automatic logic [31:0] tbase(int k);
        return (k == 0) ? 32'h7F00 : 32'h7F10;
    endfunction

    function automatic int which_tmr(logic [31:0] a);
        for (int k = 0; k < 2; k++)
            if (a >= tbase(k) && a < tbase(k) + 32'd12) return k;
        return -1;
    endfunction

    function automatic logic [31:0] treg(int k, logic [31:0] a);
        logic [31:0] off;
        off = (a - tbase(k)) / 4;
        if (off == 0) return {28'd0, m_im[k], m_mode[k], m_en[k]};
        if (off == 1) return m_pre[k];
        return m_cnt[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_en[k] = 0; m_im[k] = 0; m_pend[k] = 0; m_mode[k] = 0;
            m_pre[k] = 0; m_cnt[k] = 0; m_ph[k] = 0;
        end
    endtask

    task automatic model_step(logic rst, logic [31:0] a, logic [31:0] wd, logic [3:0] b, logic w);
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            logic        en_old = m_en[k];
            logic [31:0] off;
            case (m_ph[k])
                0: if (en_old) m_ph[k] = 1;
                1: begin m_cnt[k] = m_pre[k]; m_ph[k] = 2; end
                2: begin
                    if (!en_old) m_ph[k] = 0;
                    else if (m_cnt[k] > 1) m_cnt[k] = m_cnt[k] - 1;
                    else begin m_cnt[k] = 0; m_pend[k] = 1; m_ph[k] = 3; end
                end
                default: begin
                    if (m_mode[k] == 2'b01) begin m_pend[k] = 0; m_ph[k] = 1; end
                    else begin m_en[k] = 0; m_ph[k] = 0; end
                end
            endcase
            if (w && b == 4'hF && which_tmr(a) == k) begin
                off = (a - tbase(k)) / 4;
                if (off == 0) begin
                    m_en[k] = wd[0]; m_mode[k] = wd[2:1]; m_im[k] = wd[3]; m_pend[k] = 0;
                end else if (off == 1) begin
                    m_pre[k] = wd; m_pend[k] = 0;
                end
            end
        end
    endtask

    // Drive one bus cycle, queue the expected combinational response, advance the model.
    task automatic cyc(logic [31:0] a, logic [31:0] wd, logic [3:0] b, logic w,
                       logic ext, logic rst = 1'b0);
        exp_t e;
        int   t;
        logic dm;
        logic [31:0] dmr;
        @(negedge Clk);
        dmr = $urandom;
        addr = a; wdata = wd; be = b; we = w; ext_int = ext; Reset = rst; dm_rdata = dmr;
        t  = which_tmr(a);
        dm = (a <= 32'h2FFF);
        e.rdata    = dm ? dmr : (t >= 0 ? treg(t, a) : 32'd0);
        e.dm_addr  = a;
        e.dm_wdata = wd;
        e.dm_we    = w && dm;
        e.dm_be    = dm ? b : 4'b0000;
        e.err      = (!dm && t < 0) || (w && t >= 0 && b != 4'hF);
        e.hw       = {3'b000, ext, m_im[1] & m_pend[1], m_im[0] & m_pend[0]};
        sb.push_back(e);
        @(posedge Clk);
        model_step(rst, a, wd, b, w);
    endtask

    task automatic rd(logic [31:0] a);
        cyc(a, $urandom, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] wd);
        cyc(a, wd, 4'hF, 1'b1, 1'b0);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rdata",    rdata,             e.rdata);
                chk("dm_addr",  dm_addr,           e.dm_addr);
                chk("dm_wdata", dm_wdata,          e.dm_wdata);
                chk("dm_we",    {31'd0, dm_we},    {31'd0, e.dm_we});
                chk("dm_be",    {28'd0, dm_be},    {28'd0, e.dm_be});
                chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
                chk("hw_int",   {26'd0, hw_int},   {26'd0, e.hw});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        Reset = 1'b1; addr = '0; wdata = '0; be = '0; we = 1'b0; ext_int = 1'b0; dm_rdata = '0;
        repeat (2) @(posedge Clk);

        // Reset values
        rd(32'h7F00); rd(32'h7F04); rd(32'h7F08); rd(32'h7F18);

        // DM pass-through
        cyc(32'h10, 32'h1234_5678, 4'b0011, 1'b1, 1'b0);
        rd(32'h10);

        // One-shot timer0
        wr(32'h7F04, 32'd3);
        wr(32'h7F00, 32'h9);
        repeat (8) rd(32'h7F08);
        rd(32'h7F00);
        rd(32'h7F04);
        wr(32'h7F00, 32'h8);
        repeat (2) rd(32'h7F00);

        // Auto-reload timer1, three periods
        wr(32'h7F14, 32'd2);
        wr(32'h7F10, 32'hB);
        repeat (14) rd(32'h7F18);
        rd(32'h7F10);
        wr(32'h7F10, 32'h0);

        // Disable mid-count
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'h9);
        repeat (7) rd(32'h7F08);
        wr(32'h7F00, 32'h0);
        repeat (12) rd(32'h7F08);

        // Errors: partial timer store, unmapped load, store to reserved slot
        cyc(32'h7F04, 32'hFFFF_FFFF, 4'b0001, 1'b1, 1'b0);
        rd(32'h7F04);
        rd(32'h5000);
        wr(32'h7F0C, 32'h5);
        wr(32'h7F08, 32'h77);
        rd(32'h7F08);

        // External interrupt
        cyc(32'h20, 32'h0, 4'hF, 1'b0, 1'b1);
        cyc(32'h20, 32'h0, 4'hF, 1'b0, 1'b0);

        // Reset mid-count
        wr(32'h7F14, 32'd5);
        wr(32'h7F10, 32'hB);
        repeat (4) rd(32'h7F18);
        cyc(32'h7F18, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1);
        rd(32'h7F18); rd(32'h7F10); rd(32'h7F14);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            int          kind = $urandom_range(0, 9);
            logic [31:0] a, wd;
            logic [3:0]  b;
            logic        w;
            w  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            wd = $urandom;
            if (kind < 2) begin
                a = {18'd0, 14'($urandom_range(0, 32'h2FFF))};
            end else if (kind < 8) begin
                a = tbase(kind & 1) + 32'(4 * $urandom_range(0, 3));
                if (a[3:2] == 2'b01) wd = $urandom_range(0, 6);
                else if (a[3:2] == 2'b00) wd = {$urandom_range(0, 1) == 0 ? 28'd0 : 28'($urandom), 4'($urandom)};
            end else if (kind == 8) begin
                a = 32'h3000 + $urandom_range(0, 32'h4EFF);
            end else begin
                a = $urandom;
            end
            cyc(a, wd, b, w, 1'($urandom), $urandom_range(0, 99) == 0);
        end

        stim_done = 1;
        @(negedge Clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
